// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory handshake plus the decoder-facing
// instruction, retire and next-PC control signals.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [31:0] pc_plus4;
  logic        retire;
  logic        branch;
  logic        jump;
  logic        zero;
  logic        fetch_err;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, opcode, pc_plus4, fetch_err,
    input  imem_ready, imem_rdata, retire, branch, jump, zero
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, opcode, pc_plus4, fetch_err,
    output imem_ready, imem_rdata, retire, branch, jump, zero
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch / PC stage: FETCH over req/ready, hold in EXEC, update PC on retire.
// Optional fetch timeout with sticky error state is compiled in by `FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_TIMEOUT_EN
  , parameter logic [7:0] FETCH_TIMEOUT = 8'd15
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  instr_fetch_unit_if.master          bus
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPC_W  = 6;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   instr_q;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   br_off;
  logic [XLEN-1:0]   pc_d;

`ifdef FETCH_TIMEOUT_EN
  logic [CNT_W-1:0]  cnt_q;
`endif

  assign pc_plus4 = pc_q + XLEN'(4);
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Next PC: jump beats taken branch beats sequential.
  always_comb begin
    pc_d = pc_plus4;
    if (bus.jump) begin
      pc_d = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (bus.branch && bus.zero) begin
      pc_d = pc_plus4 + br_off;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
`ifdef FETCH_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        S_FETCH: begin
          if (bus.imem_ready) begin
            instr_q <= bus.imem_rdata;
            state_q <= S_EXEC;
          end
`ifdef FETCH_TIMEOUT_EN
          // A ready on the limit cycle still wins over the timeout.
          else if (cnt_q == FETCH_TIMEOUT) begin
            state_q <= S_ERR;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        S_EXEC: begin
          if (bus.retire) begin
            pc_q    <= pc_d;
            state_q <= S_FETCH;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  // Outputs decode from registered state only; no input-to-output paths.
  assign bus.imem_req    = (state_q == S_FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state_q == S_EXEC);
  assign bus.opcode      = (state_q == S_EXEC) ? instr_q[31:26] : OPC_W'(6'h3F);
  assign bus.pc_plus4    = pc_plus4;
`ifdef FETCH_TIMEOUT_EN
  assign bus.fetch_err   = (state_q == S_ERR);
`else
  assign bus.fetch_err   = 1'b0;
`endif

endmodule
